// File: rtl/mem_burst_accel.sv
`default_nettype none
// =============================================================================
// mem_burst_accel : RoCC burst accelerator (STORE/LOAD/FILL/LOAD_SUM/SET_LEN)
// Revision        : 1.0 - initial release
// =============================================================================
module mem_burst_accel #(
  parameter int         ADDR_W       = 40,
  parameter int         LEN_W        = 8,
  parameter int         MAX_INFLIGHT = 4,
  parameter logic [2:0] MEM_TYP      = 3'b011
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [159:0]      cmd,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  output logic [73:0]       resp,
  output logic              resp_vld,
  input  logic              resp_rdy,
  input  logic              mem_req_rdy,
  output logic              mem_req_vld,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [4:0]        mem_req_cmd,
  output logic [2:0]        mem_req_typ,
  output logic [63:0]       mem_req_data,
  input  logic              mem_resp_vld,
  input  logic [63:0]       mem_resp_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [6:0]       F_STORE    = 7'd0;
  localparam logic [6:0]       F_LOAD     = 7'd1;
  localparam logic [6:0]       F_FILL     = 7'd2;
  localparam logic [6:0]       F_LOAD_SUM = 7'd3;
  localparam logic [6:0]       F_SET_LEN  = 7'd4;
  localparam logic [LEN_W-1:0] MAX_OUT    = LEN_W'(MAX_INFLIGHT);

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  total_q, total_d;
  logic [LEN_W-1:0]  issued_q, issued_d;
  logic [LEN_W-1:0]  received_q, received_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       data_q, data_d;
  logic [63:0]       resp_data_q, resp_data_d;
  logic [4:0]        rd_q, rd_d;
  logic              xd_q, xd_d;
  logic              store_q, store_d;

  logic [6:0]        cmd_funct;
  logic [63:0]       cmd_rs1;
  logic [63:0]       cmd_rs2;
  logic [LEN_W-1:0]  outstanding;
  logic              fire;
  logic              is_mem;
  logic              unused_cmd_bits;

  assign cmd_funct = cmd[6:0];
  assign cmd_rs1   = cmd[95:32];
  assign cmd_rs2   = cmd[159:96];
  assign unused_cmd_bits = ^{cmd[16:7], cmd[19:18], cmd[31:25], cmd[159:96+ADDR_W]};

  assign outstanding  = issued_q - received_q;
  assign cmd_rdy      = (state_q == IDLE);
  assign resp_vld     = (state_q == RESP);
  assign mem_req_vld  = (state_q == ISSUE) && (outstanding < MAX_OUT);
  assign fire         = mem_req_vld && mem_req_rdy;
  assign mem_req_addr = addr_q;
  assign mem_req_data = data_q;
  assign mem_req_cmd  = {4'b0000, store_q};
  assign mem_req_typ  = MEM_TYP;
  assign resp         = {resp_data_q, rd_q, mem_req_vld, 3'b000, (state_q != IDLE)};

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    total_d     = total_q;
    issued_d    = issued_q;
    received_d  = received_q;
    addr_d      = addr_q;
    data_d      = data_q;
    resp_data_d = resp_data_q;
    rd_d        = rd_q;
    xd_d        = xd_q;
    store_d     = store_q;
    is_mem      = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_vld) begin
          rd_d       = cmd[24:20];
          xd_d       = cmd[17];
          issued_d   = '0;
          received_d = '0;
          addr_d     = cmd_rs2[ADDR_W-1:0];
          data_d     = cmd_rs1;
          store_d    = 1'b0;
          total_d    = LEN_W'(1);
          case (cmd_funct)
            F_STORE: begin
              store_d     = 1'b1;
              resp_data_d = cmd_rs1;
              is_mem      = 1'b1;
            end
            F_LOAD: begin
              resp_data_d = '0;
              is_mem      = 1'b1;
            end
            F_FILL: begin
              store_d     = 1'b1;
              total_d     = len_q;
              resp_data_d = 64'(len_q);
              is_mem      = (len_q != '0);
            end
            F_LOAD_SUM: begin
              total_d     = len_q;
              resp_data_d = '0;
              is_mem      = (len_q != '0);
            end
            F_SET_LEN: begin
              len_d       = cmd_rs1[LEN_W-1:0];
              resp_data_d = 64'(len_q);
            end
            default: resp_data_d = '1;
          endcase
          if (is_mem) begin
            state_d = ISSUE;
          end else if (cmd[17]) begin
            state_d = RESP;
          end
        end
      end
      ISSUE, DRAIN: begin
        if (fire) begin
          issued_d = issued_q + LEN_W'(1);
          addr_d   = addr_q + ADDR_W'(8);
        end
        // Loads accumulate into the response register; a single LOAD is a one-word sum.
        if (mem_resp_vld) begin
          received_d = received_q + LEN_W'(1);
          if (!store_q) begin
            resp_data_d = resp_data_q + mem_resp_data;
          end
        end
        if (state_q == ISSUE) begin
          if (issued_d == total_q) begin
            state_d = DRAIN;
          end
        end else if (received_d == total_q) begin
          state_d = xd_q ? RESP : IDLE;
        end
      end
      RESP: begin
        if (resp_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= LEN_W'(1);
      total_q     <= '0;
      issued_q    <= '0;
      received_q  <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      resp_data_q <= '0;
      rd_q        <= '0;
      xd_q        <= 1'b0;
      store_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      total_q     <= total_d;
      issued_q    <= issued_d;
      received_q  <= received_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      resp_data_q <= resp_data_d;
      rd_q        <= rd_d;
      xd_q        <= xd_d;
      store_q     <= store_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_burst_accel.md
# mem_burst_accel

Parametrised RoCC-style memory accelerator: next generation of the single-word load/store accelerator. It adds a programmable burst length, multi-word FILL and LOAD_SUM commands, and up to MAX_INFLIGHT outstanding in-order memory requests. It keeps the same 160-bit command and 74-bit response formats and sits between the core's RoCC command/response ports and the L1 memory request/response port.

## Interface
- ADDR_W, 40, memory address width; mem_req_addr = low ADDR_W bits of the running address.
- LEN_W, 8, burst-length register width; max burst = 2^LEN_W-1.
- MAX_INFLIGHT, 4, max issued-but-unanswered memory requests (1..15).
- MEM_TYP, 3'b011, constant driven on mem_req_typ (64-bit access).
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- cmd  in  160  funct[6:0], rs2[11:7], rs1[16:12], xd[17], xs1[18], xs2[19], rd[24:20], opcode[31:25], rs1_data[95:32], rs2_data[159:96].
- cmd_vld  in  1  command valid.
- cmd_rdy  out  1  high only in IDLE.
- resp  out  74  {resp_data[63:0], resp_rd[4:0], mem_req_vld, 1'b0, 1'b0, 1'b0 (interrupt), busy}; busy = state != IDLE.
- resp_vld  out  1  response valid.
- resp_rdy  in  1  response accepted.
- mem_req_rdy  in  1  memory accepts request.
- mem_req_vld  out  1  request valid.
- mem_req_addr  out  ADDR_W  request address.
- mem_req_cmd  out  5  5'd0 load, 5'd1 store.
- mem_req_typ  out  3  MEM_TYP.
- mem_req_data  out  64  store data.
- mem_resp_vld  in  1  one pulse per request, in request order (loads and stores).
- mem_resp_data  in  64  load data.

## Operation
- funct 0 STORE: one store of rs1_data to rs2_data; resp_data = rs1_data.
- funct 1 LOAD: one load from rs2_data; resp_data = loaded word.
- funct 2 FILL: len stores of rs1_data at rs2_data + 8*i, i=0..len-1; resp_data = len (zero-extended).
- funct 3 LOAD_SUM: len loads from rs2_data + 8*i; resp_data = sum modulo 2^64.
- funct 4 SET_LEN: len <= rs1_data[LEN_W-1:0]; no memory traffic; resp_data = previous len.
- Other funct: no memory traffic; resp_data = all ones.
- FILL/LOAD_SUM with len 0: no memory traffic, resp_data = 0.
- Response is produced only if cmd xd=1; with xd=0 the block returns to IDLE after completion without asserting resp_vld.
- States: IDLE -> ISSUE (memory command, count > 0) -> DRAIN (all requests issued) -> RESP (xd=1) -> IDLE. Non-memory commands and zero-length bursts go IDLE -> RESP (xd=1) or stay in IDLE (xd=0). DRAIN exits on the last mem_resp_vld. RESP exits on resp_vld && resp_rdy.
- Counters: issued, received (LEN_W bits); outstanding = issued - received.
- Address register advances by 8 per fired request and wraps modulo 2^ADDR_W.
- mem_req_vld = (state==ISSUE) && (outstanding < MAX_INFLIGHT). The request fires on mem_req_vld && mem_req_rdy.
- A fire and a mem_resp_vld in the same cycle leave outstanding unchanged; both counters update.
- mem_resp_vld in IDLE or RESP is ignored.
- resp_rd is captured from cmd rd at command accept.

## Timing
- Reset (async, immediate): state IDLE, counters 0, len = 1, accumulator 0, resp_data 0, resp_rd 0, resp_vld 0, mem_req_vld 0, mem_req_addr 0, mem_req_data 0, mem_req_cmd 0, busy 0, cmd_rdy 1. mem_req_typ = MEM_TYP at all times.
- Reset mid-burst abandons all outstanding requests; memory responses arriving after reset are ignored.
- Command accepted at cycle T (cmd_vld && cmd_rdy). mem_req_vld is first high at T+1; address, data and cmd are registered at T.
- Request signals hold stable while mem_req_vld=1 and mem_req_rdy=0.
- Last mem_resp_vld at cycle P -> resp_vld=1 at P+1; the sum includes the data from cycle P.
- Non-memory command accepted at T -> resp_vld=1 at T+1.
- resp_vld and resp_data hold until resp_rdy. cmd_rdy rises the cycle after the response handshake.
- With mem_req_rdy=1 and memory latency L ≥ MAX_INFLIGHT, requests stall after MAX_INFLIGHT issues and resume one per response.

## Test plan
- After reset: SET_LEN rs1=3 (xd=1), then LOAD_SUM rs2=0x100 with mem returning 5, 7, 9 -> addresses 0x100, 0x108, 0x110; resp_data = 21; the rd field echoes the command.
- FILL len=4, rs1=0xDEAD, rs2=0xFFFFFFFFF8 (ADDR_W=40), mem_req_rdy=1, response latency 10 -> exactly 4 stores; addresses wrap to 0x0, 0x8, 0x10; mem_req_vld stalls after 4 outstanding; resp_data = 4.
- STORE with xd=0 -> one store, no resp_vld, cmd_rdy=1 one cycle after its mem_resp_vld. LOAD with resp_rdy held 0 for 5 cycles -> resp_vld and data stable throughout.
- SET_LEN 0 then LOAD_SUM -> no mem_req_vld, resp_data = 0 at T+1. funct 9 -> resp_data = 0xFFFF_FFFF_FFFF_FFFF.
- Simultaneous request fire and mem_resp_vld every cycle with len=200 -> outstanding stays at 1, sum correct.
- rst asserted mid-burst with 2 requests outstanding -> all outputs are at reset values before the next clock; late mem_resp_vld pulses are ignored; a following LOAD completes normally.
